// File: rtl/signed_div_pkg.sv
// Shared constants for the iterative restoring divider: FSM encoding,
// counter sizing helper and the value forced onto the quotient on divide-by-zero.
package signed_div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // Wide enough for any supported quotient width; sliced to A_WIDTH at use.
  localparam logic [63:0] DIV0_QUOT_ALL = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/signed_div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract
// the divisor magnitude when it fits. Purely combinational.
module div_restore_step #(
  parameter int B_WIDTH = 8
) (
  input  logic [B_WIDTH:0]   part_in,
  input  logic               bit_in,
  input  logic [B_WIDTH-1:0] dsr_mag,
  output logic [B_WIDTH:0]   part_out,
  output logic               q_bit
);

  logic [B_WIDTH+1:0] shifted;
  logic [B_WIDTH:0]   diff;

  assign shifted = {part_in, bit_in};
  // The partial stays below the divisor, so the low B_WIDTH+1 bits hold the exact difference.
  assign diff    = shifted[B_WIDTH:0] - {1'b0, dsr_mag};
  assign q_bit   = (shifted >= {2'b00, dsr_mag});
  assign part_out = q_bit ? diff : shifted[B_WIDTH:0];

endmodule

// File: rtl/signed_div.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock.
// Optional abort input enabled by defining SIGNED_DIV_ABORT_EN.
module signed_div
  import signed_div_pkg::*;
#(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
  input  logic [A_WIDTH-1:0] dividend,
  input  logic [B_WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] quotient,
  output logic [B_WIDTH-1:0] remainder,
  output logic               div_zero
);

  localparam int CNT_W = (clog2(A_WIDTH) < 1) ? 1 : clog2(A_WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] dvd_q, dvd_d;
  logic [B_WIDTH-1:0] dsr_q, dsr_d;
  logic [B_WIDTH:0]   part_q, part_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_q, zero_d;
  logic [B_WIDTH-1:0] raw_lo_q, raw_lo_d;
  logic [A_WIDTH-1:0] quot_q, quot_d;
  logic [B_WIDTH-1:0] rem_q, rem_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;

  logic               sa, sb;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [B_WIDTH:0]   step_part;
  logic               step_bit;
  logic [B_WIDTH-1:0] rem_mag;

  assign sa      = tc & dividend[A_WIDTH-1];
  assign sb      = tc & divisor[B_WIDTH-1];
  assign a_mag   = sa ? -dividend : dividend;
  assign b_mag   = sb ? -divisor : divisor;
  assign rem_mag = part_q[B_WIDTH-1:0];

  div_restore_step #(.B_WIDTH(B_WIDTH)) u_step (
    .part_in  (part_q),
    .bit_in   (dvd_q[A_WIDTH-1]),
    .dsr_mag  (dsr_q),
    .part_out (step_part),
    .q_bit    (step_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    part_d     = part_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;
    raw_lo_d   = raw_lo_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          part_d     = '0;
          neg_quot_d = sa ^ sb;
          neg_rem_d  = sa;
          zero_d     = (divisor == '0);
          raw_lo_d   = dividend[B_WIDTH-1:0];
          cnt_d      = CNT_W'(A_WIDTH - 1);
          state_d    = CALC;
        end
      end
      // The dividend register doubles as the quotient: MSB shifts out, result bit shifts in.
      CALC: begin
        part_d = step_part;
        dvd_d  = {dvd_q[A_WIDTH-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (zero_q) begin
          quot_d     = DIV0_QUOT_ALL[A_WIDTH-1:0];
          rem_d      = raw_lo_q;
          div_zero_d = 1'b1;
        end else begin
          quot_d     = neg_quot_q ? -dvd_q : dvd_q;
          rem_d      = neg_rem_q ? -rem_mag : rem_mag;
          div_zero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SIGNED_DIV_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_zero_d = div_zero_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      part_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      raw_lo_q   <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      part_q     <= part_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
      raw_lo_q   <= raw_lo_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_signed_div.sv
// Directed self-checking bench for signed_div (A_WIDTH=16, B_WIDTH=8).
// Covers the abort input too when SIGNED_DIV_ABORT_EN is defined.
module tb_signed_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tc;
  logic [15:0] dividend;
  logic [7:0]  divisor;
`ifdef SIGNED_DIV_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int saw_done;

  signed_div #(.A_WIDTH(16), .B_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tc        (tc),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef SIGNED_DIV_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples them cleanly at the next rising edge.
  task automatic applyStimulus(input logic t, input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    tc       = t;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
  endtask

  // Counts falling edges after start until done is seen; bounded at 40.
  task automatic waitDone(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) break;
    end
  endtask

  task automatic checkResult(input string tag, input logic [15:0] q, input logic [7:0] r,
                             input logic dz);
    checkOutput({tag, "_quot"}, quotient, q);
    checkOutput({tag, "_rem"}, remainder, r);
    checkOutput({tag, "_dz"}, div_zero, dz);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tc       = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SIGNED_DIV_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkResult("reset", 16'h0000, 8'h00, 1'b0);

    applyStimulus(1'b0, 16'd1000, 8'd7);
    waitDone(lat);
    checkOutput("u1000_7_latency", lat, 18);
    checkOutput("u1000_7_busy_at_done", busy, 0);
    checkResult("u1000_7", 16'h008E, 8'h06, 1'b0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);

    applyStimulus(1'b1, 16'hFC18, 8'd7);
    waitDone(lat);
    checkResult("sneg_pos", 16'hFF72, 8'hFA, 1'b0);

    applyStimulus(1'b1, 16'd1000, 8'hF9);
    waitDone(lat);
    checkResult("spos_neg", 16'hFF72, 8'h06, 1'b0);

    applyStimulus(1'b1, 16'hFC18, 8'hF9);
    waitDone(lat);
    checkResult("sneg_neg", 16'h008E, 8'hFA, 1'b0);

    applyStimulus(1'b1, 16'h8000, 8'hFF);
    waitDone(lat);
    checkResult("s_overflow", 16'h8000, 8'h00, 1'b0);

    applyStimulus(1'b0, 16'hFFFF, 8'hFF);
    waitDone(lat);
    checkResult("u_max", 16'h0101, 8'h00, 1'b0);

    applyStimulus(1'b0, 16'd123, 8'd0);
    waitDone(lat);
    checkOutput("u_div0_latency", lat, 18);
    checkResult("u_div0", 16'hFFFF, 8'h7B, 1'b1);

    applyStimulus(1'b1, 16'd123, 8'd0);
    waitDone(lat);
    checkResult("s_div0", 16'hFFFF, 8'h7B, 1'b1);

    applyStimulus(1'b0, 16'd10, 8'd3);
    waitDone(lat);
    checkResult("after_div0", 16'h0003, 8'h01, 1'b0);

    // A start pulse in the middle of CALC must not disturb the running operation.
    applyStimulus(1'b0, 16'd1000, 8'd7);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      start = (lat == 5);
      if (lat == 5) begin
        tc       = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end
      lat++;
      if (done) break;
    end
    checkOutput("busy_start_latency", lat, 18);
    checkResult("busy_start", 16'h008E, 8'h06, 1'b0);

    // Start raised in the done cycle itself is accepted.
    tc       = 1'b0;
    dividend = 16'd10;
    divisor  = 8'd3;
    start    = 1'b1;
    waitDone(lat);
    checkOutput("b2b_latency", lat, 18);
    checkResult("b2b", 16'h0003, 8'h01, 1'b0);

    applyStimulus(1'b0, 16'd1000, 8'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkResult("midrst", 16'h0000, 8'h00, 1'b0);
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    checkOutput("midrst_no_done", saw_done, 0);

`ifdef SIGNED_DIV_ABORT_EN
    applyStimulus(1'b0, 16'd1000, 8'd7);
    waitDone(lat);
    checkResult("pre_abort", 16'h008E, 8'h06, 1'b0);
    applyStimulus(1'b0, 16'd50, 8'd5);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkResult("abort_hold", 16'h008E, 8'h06, 1'b0);
    saw_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    checkOutput("abort_no_done", saw_done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
